// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: debug/hazard controls and instruction-memory data in,
// PC and IF/ID register contents out.
interface fetch_stage_if;
    logic        enable;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_addr;
    logic [31:0] instr_in;
    logic [31:0] pc_addr;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc_next;
    logic        if_id_valid;
    logic        halted;
    logic        addr_error;
    logic [31:0] fetch_count;

    modport master (
        output enable, stall, redirect_valid, redirect_addr, instr_in,
        input  pc_addr, if_id_instr, if_id_pc_next, if_id_valid,
               halted, addr_error, fetch_count
    );

    modport slave (
        input  enable, stall, redirect_valid, redirect_addr, instr_in,
        output pc_addr, if_id_instr, if_id_pc_next, if_id_valid,
               halted, addr_error, fetch_count
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the word-indexed PC, captures memory read data into
// IF/ID with stall, redirect/flush, HALT and debug run gating.
module fetch_stage #(
    parameter int          MEM_DEPTH   = 32,
    parameter logic [5:0]  HALT_OPCODE = 6'b111111,
    parameter logic [31:0] NOP_WORD    = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          rst,
    fetch_stage_if.slave  bus
);
    localparam int              PC_W    = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [31:0]     DEPTH_W = 32'(MEM_DEPTH);
    localparam logic [PC_W-1:0] PC_LAST = PC_W'(MEM_DEPTH - 1);

    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] pc_inc;
    logic [PC_W-1:0] redir_pc;
    logic            redir_oob;
    logic            is_halt;
    logic [31:0]     if_id_instr;
    logic [PC_W-1:0] if_id_pc_next;
    logic            if_id_valid;
    logic            halted;
    logic            addr_error;
    logic [31:0]     fetch_count;

    // Explicit wrap keeps the PC in range for non-power-of-two depths too.
    assign pc_inc    = (pc == PC_LAST) ? '0 : pc + PC_W'(1);
    assign redir_pc  = PC_W'(bus.redirect_addr % DEPTH_W);
    assign redir_oob = (bus.redirect_addr >= DEPTH_W);
    assign is_halt   = (bus.instr_in[31:26] == HALT_OPCODE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc            <= '0;
            if_id_instr   <= NOP_WORD;
            if_id_pc_next <= '0;
            if_id_valid   <= 1'b0;
            halted        <= 1'b0;
            addr_error    <= 1'b0;
            fetch_count   <= '0;
        end else if (bus.enable) begin
            if (bus.redirect_valid) begin
                // Redirect wins over stall and halt: the fetched word is wrong-path.
                pc            <= redir_pc;
                if_id_instr   <= NOP_WORD;
                if_id_pc_next <= '0;
                if_id_valid   <= 1'b0;
                halted        <= 1'b0;
                if (redir_oob)
                    addr_error <= 1'b1;
            end else if (halted) begin
                if_id_instr   <= NOP_WORD;
                if_id_pc_next <= '0;
                if_id_valid   <= 1'b0;
            end else if (!bus.stall) begin
                if_id_instr   <= bus.instr_in;
                if_id_pc_next <= pc_inc;
                if_id_valid   <= 1'b1;
                if (fetch_count != '1)
                    fetch_count <= fetch_count + 32'd1;
                // HALT is delivered and counted, but the PC parks on it.
                if (is_halt)
                    halted <= 1'b1;
                else
                    pc <= pc_inc;
            end
        end
    end

    assign bus.pc_addr       = 32'(pc);
    assign bus.if_id_instr   = if_id_instr;
    assign bus.if_id_pc_next = 32'(if_id_pc_next);
    assign bus.if_id_valid   = if_id_valid;
    assign bus.halted        = halted;
    assign bus.addr_error    = addr_error;
    assign bus.fetch_count   = fetch_count;
endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: memory model answers on negedge, expected
// IF/ID contents are queued when an advance is set up and checked after the edge.
module tb_fetch_stage;
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc_next;
    } exp_t;

    localparam logic [31:0] HALT_W = 32'hFC00_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] mem [32];
    exp_t        sb_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_cnt = 0;

    fetch_stage_if bus();

    fetch_stage #(.MEM_DEPTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // Instruction memory: word for pc_addr appears on the negedge after it changes.
    always @(negedge clk) bus.instr_in = mem[bus.pc_addr[4:0]];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_fetch(input logic [31:0] instr, input logic [31:0] pc_next);
        exp_t e;
        e.instr   = instr;
        e.pc_next = pc_next;
        sb_q.push_back(e);
        exp_cnt++;
    endtask

    task automatic chk_fetch(input string tag);
        exp_t e;
        if (sb_q.size() == 0) begin
            chk({tag, "_queue"}, 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            chk({tag, "_instr"}, bus.if_id_instr, e.instr);
            chk({tag, "_pcnext"}, bus.if_id_pc_next, e.pc_next);
            chk({tag, "_valid"}, {31'd0, bus.if_id_valid}, 32'd1);
            chk({tag, "_count"}, bus.fetch_count, exp_cnt);
        end
    endtask

    task automatic redirect(input logic [31:0] addr);
        bus.redirect_valid = 1'b1;
        bus.redirect_addr  = addr;
        tick();
        bus.redirect_valid = 1'b0;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_pc"}, bus.pc_addr, 32'd0);
        chk({tag, "_instr"}, bus.if_id_instr, 32'd0);
        chk({tag, "_pcnext"}, bus.if_id_pc_next, 32'd0);
        chk({tag, "_valid"}, {31'd0, bus.if_id_valid}, 32'd0);
        chk({tag, "_halted"}, {31'd0, bus.halted}, 32'd0);
        chk({tag, "_err"}, {31'd0, bus.addr_error}, 32'd0);
        chk({tag, "_count"}, bus.fetch_count, 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 32'h2000_0000 | 32'(i);
        mem[0] = 32'h0022_1820;
        mem[1] = 32'h0022_1822;
        mem[2] = 32'h0022_1824;
        mem[3] = 32'h0022_1825;
        mem[5] = HALT_W;
        bus.enable         = 1'b1;
        bus.stall          = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_addr  = 32'd0;
        bus.instr_in       = 32'd0;

        #1;
        chk_reset("rst");
        @(negedge clk);
        rst = 1'b0;

        // Straight-line fetch of mem[0..3]
        for (int i = 0; i < 4; i++) begin
            exp_fetch(mem[i], 32'(i + 1));
            tick();
            chk_fetch($sformatf("seq%0d", i));
        end
        chk("seq_pc", bus.pc_addr, 32'd4);
        chk("seq_cnt", bus.fetch_count, 32'd4);

        // Stall holding mem[1] with pc 2
        redirect(32'd1);
        exp_fetch(mem[1], 32'd2);
        tick();
        chk_fetch("pre_stall");
        bus.stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("stall_pc", bus.pc_addr, 32'd2);
            chk("stall_instr", bus.if_id_instr, mem[1]);
            chk("stall_pcnext", bus.if_id_pc_next, 32'd2);
        end
        bus.stall = 1'b0;
        exp_fetch(mem[2], 32'd3);
        tick();
        chk_fetch("post_stall");
        chk("post_stall_pc", bus.pc_addr, 32'd3);

        // Redirect beats a simultaneous stall
        redirect(32'd10);
        chk("r10_pc", bus.pc_addr, 32'd10);
        bus.stall = 1'b1;
        redirect(32'd4);
        bus.stall = 1'b0;
        chk("flush_pc", bus.pc_addr, 32'd4);
        chk("flush_valid", {31'd0, bus.if_id_valid}, 32'd0);
        chk("flush_instr", bus.if_id_instr, 32'd0);
        exp_fetch(mem[4], 32'd5);
        tick();
        chk_fetch("after_flush");

        // HALT at pc 5, drain, then leave via redirect
        exp_fetch(HALT_W, 32'd6);
        tick();
        chk_fetch("halt");
        chk("halt_flag", {31'd0, bus.halted}, 32'd1);
        chk("halt_pc", bus.pc_addr, 32'd5);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("drain_valid", {31'd0, bus.if_id_valid}, 32'd0);
            chk("drain_pc", bus.pc_addr, 32'd5);
            chk("drain_cnt", bus.fetch_count, exp_cnt);
        end
        redirect(32'd0);
        chk("unhalt", {31'd0, bus.halted}, 32'd0);
        chk("unhalt_pc", bus.pc_addr, 32'd0);
        exp_fetch(mem[0], 32'd1);
        tick();
        chk_fetch("resume");

        // Wrap at the last word and out-of-range redirect
        redirect(32'd31);
        exp_fetch(mem[31], 32'd0);
        tick();
        chk_fetch("wrap");
        chk("wrap_pc", bus.pc_addr, 32'd0);
        chk("no_err", {31'd0, bus.addr_error}, 32'd0);
        redirect(32'd40);
        chk("oob_pc", bus.pc_addr, 32'd8);
        chk("oob_err", {31'd0, bus.addr_error}, 32'd1);
        redirect(32'd3);
        chk("sticky_pc", bus.pc_addr, 32'd3);
        chk("sticky_err", {31'd0, bus.addr_error}, 32'd1);

        // Debug freeze ignores redirect and stall
        exp_fetch(mem[3], 32'd4);
        tick();
        chk_fetch("pre_freeze");
        bus.enable         = 1'b0;
        bus.redirect_valid = 1'b1;
        bus.redirect_addr  = 32'd20;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("frz_pc", bus.pc_addr, 32'd4);
            chk("frz_instr", bus.if_id_instr, mem[3]);
            chk("frz_pcnext", bus.if_id_pc_next, 32'd4);
            chk("frz_valid", {31'd0, bus.if_id_valid}, 32'd1);
            chk("frz_cnt", bus.fetch_count, exp_cnt);
        end
        bus.enable         = 1'b1;
        bus.redirect_valid = 1'b0;

        // Async reset between edges while stalled
        bus.stall = 1'b1;
        tick();
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk_reset("async_rst");
        exp_cnt = 0;
        @(negedge clk);
        rst = 1'b0;
        bus.stall = 1'b0;
        exp_fetch(mem[0], 32'd1);
        tick();
        chk_fetch("post_rst");
        chk("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch stage feeding the instruction memory and the IF/ID pipeline register. Owns the word-indexed program counter and drives it as the memory read address; the memory returns the word on the following negedge. Captures the returned instruction into IF/ID, handling hazard stalls, branch/jump redirects (flush), a HALT opcode and debug-unit run gating.

Parameters:
MEM_DEPTH, 32, number of instruction words; PC range 0..MEM_DEPTH-1
HALT_OPCODE, 6'b111111, instr[31:26] value treated as HALT
NOP_WORD, 32'h0000_0000, bubble word placed in IF/ID

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  reset, asynchronous, active-high
enable  in  1  debug-unit run/step gate; 0 = freeze all state
stall  in  1  hazard-unit stall; hold PC and IF/ID
redirect_valid  in  1  taken branch/jump this cycle
redirect_addr  in  32  word address of the redirect target
instr_in  in  32  instruction memory read data for pc_addr
pc_addr  out  32  current PC, instruction memory read address
if_id_instr  out  32  IF/ID instruction
if_id_pc_next  out  32  IF/ID PC+1 of the captured instruction
if_id_valid  out  1  IF/ID holds a real instruction
halted  out  1  HALT fetched; fetch stopped
addr_error  out  1  sticky; redirect target was >= MEM_DEPTH
fetch_count  out  32  instructions delivered to IF/ID, saturating

Behaviour:
- Reset (async, immediate): pc_addr=0, if_id_instr=NOP_WORD, if_id_pc_next=0, if_id_valid=0, halted=0, addr_error=0, fetch_count=0.
- pc_addr is registered and changes only on posedge. instr_in sampled at posedge N belongs to the pc_addr driven after posedge N-1. Fetch-to-IF/ID latency is 1 cycle.
- Per-posedge priority, highest first:
  1. enable=0: hold everything.
  2. redirect_valid=1, regardless of stall or halted:
     - pc <= redirect_addr mod MEM_DEPTH.
     - IF/ID <= NOP_WORD, valid=0, pc_next=0.
     - halted <= 0.
     - addr_error <= 1 if redirect_addr >= MEM_DEPTH.
     - fetch_count unchanged.
  3. halted=1: pc holds. IF/ID <= NOP_WORD, valid=0, so the pipeline drains.
  4. stall=1: pc and all IF/ID fields hold.
  5. Advance:
     - IF/ID <= instr_in, valid=1, pc_next = pc+1 (mod MEM_DEPTH).
     - fetch_count++ (saturates at 32'hFFFF_FFFF).
     - If instr_in[31:26]==HALT_OPCODE: halted <= 1 and pc holds. Otherwise pc <= (pc==MEM_DEPTH-1) ? 0 : pc+1.
- Wrap-around: PC never leaves 0..MEM_DEPTH-1.
- HALT itself enters IF/ID as a valid instruction and is counted. Only a redirect or reset leaves the halted state.
- addr_error is cleared only by reset.
- Reset asserted mid-stall/halt/redirect: outputs take reset values immediately, with no clock needed. First advancing posedge after release captures mem[0] with if_id_pc_next=1.

Test Plan:
1. Reset, enable=1, mem[0..3]=add,sub,and,or, 4 posedges -> if_id_instr sequence add,sub,and,or; if_id_pc_next 1,2,3,4; pc_addr=4; fetch_count=4.
2. After IF/ID holds mem[1] with pc_addr=2, assert stall for 2 cycles -> pc_addr stays 2 and IF/ID stays mem[1]/pc_next=2 for both. After release, the next edge gives IF/ID=mem[2], pc_addr=3.
3. pc_addr=10, redirect_valid=1, redirect_addr=4 (stall=1 simultaneously) -> pc_addr=4, if_id_valid=0, if_id_instr=0. Next edge -> IF/ID=mem[4], pc_next=5.
4. mem[5]=32'hFC00_0000 reached from pc 5 -> IF/ID=HALT, valid=1, halted=1, pc_addr stays 5. Following 3 edges -> valid=0. fetch_count frozen. Then redirect to 0 -> halted=0, fetch resumes from mem[0].
5. pc_addr=31, advance -> pc_addr=0. redirect_addr=40 -> pc_addr=8, addr_error=1, persisting after further redirects.
6. enable=0 for 3 cycles mid-run -> no output changes. Assert rst between clock edges during stall -> all outputs reset immediately.
